// File: rtl/ipic_lite_pkg.sv
// Shared encodings for the IPIC lite master engine and the requester arbiter.
package ipic_lite_pkg;

   localparam int unsigned IPIC_TYPE_W = 3;

   // Engine transaction types, shared with the single-beat master engine
   localparam logic [IPIC_TYPE_W-1:0] IPIC_TYPE_SINGLE_RD = 3'd2;
   localparam logic [IPIC_TYPE_W-1:0] IPIC_TYPE_SINGLE_WR = 3'd3;

   localparam int unsigned ARB_STATE_W = 3;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE     = 3'd0,
      ARB_ISSUE    = 3'd1,
      ARB_COMPLETE = 3'd2,
      ARB_DRAIN    = 3'd3,
      ARB_HANG     = 3'd4
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_priority_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          any
);

   int pos;

   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = 1; k <= int'(N); k++) begin
         pos = (int'(ptr) + k) % int'(N);
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            index      = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/ipic_lite_arbiter.sv
// Round-robin arbiter sharing one IPIC lite single-beat master engine among
// NUM_REQ requesters, with a transaction timeout that parks the block.
module ipic_lite_arbiter
   import ipic_lite_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_WIDTH       = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              req_ack,
   output logic [NUM_REQ-1:0]              resp_valid,
   output logic                            resp_err,
   output logic [DATA_WIDTH-1:0]           resp_rdata,
   output logic [IPIC_TYPE_W-1:0]          ipic_type,
   output logic                            ipic_start,
   input  logic                            ipic_done,
   output logic [ADDR_WIDTH-1:0]           read_addr,
   output logic [ADDR_WIDTH-1:0]           write_addr,
   output logic [DATA_WIDTH-1:0]           write_data,
   input  logic [DATA_WIDTH-1:0]           single_read_data,
   output logic                            arb_hang,
   output logic [ARB_STATE_W-1:0]          arb_state
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   arb_state_e             state_q, state_d;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]          sel_q, sel_d;
   logic [TO_WIDTH-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [NUM_REQ-1:0]     rv_q, rv_d;
   logic                   err_q, err_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic [IPIC_TYPE_W-1:0] type_q, type_d;
   logic                   start_q, start_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   hang_q, hang_d;

   logic [NUM_REQ-1:0]     pick_grant;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;

   rr_priority_picker #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_picker (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .index (pick_idx),
      .any   (pick_any)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= IW'(NUM_REQ - 1);
         sel_q    <= '0;
         cnt_q    <= '0;
         ack_q    <= '0;
         rv_q     <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         type_q   <= IPIC_TYPE_SINGLE_RD;
         start_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         hang_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         rv_q     <= rv_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         type_q   <= type_d;
         start_q  <= start_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         hang_q   <= hang_d;
      end
   end

   // Next-state and next-output logic; ack/resp/err are single-cycle pulses
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      ack_d    = '0;
      rv_d     = '0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      type_d   = type_q;
      start_d  = start_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      hang_d   = hang_q;

      case (state_q)
         ARB_IDLE: begin
            // No grant while the engine still reports done from a prior beat
            if (pick_any && !ipic_done) begin
               sel_d    = pick_idx;
               rr_ptr_d = pick_idx;
               cnt_d    = '0;
               ack_d    = pick_grant;
               addr_d   = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d  = req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               type_d   = req_wr[pick_idx] ? IPIC_TYPE_SINGLE_WR : IPIC_TYPE_SINGLE_RD;
               start_d  = 1'b1;
               state_d  = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            cnt_d = cnt_q + TO_WIDTH'(1);
            if (ipic_done) begin
               start_d = 1'b0;
               rdata_d = single_read_data;
               rv_d    = NUM_REQ'(1) << sel_q;
               state_d = ARB_COMPLETE;
            end else if (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               start_d = 1'b0;
               rv_d    = NUM_REQ'(1) << sel_q;
               err_d   = 1'b1;
               hang_d  = 1'b1;
               state_d = ARB_HANG;
            end
         end
         ARB_COMPLETE: begin
            state_d = ARB_DRAIN;
         end
         ARB_DRAIN: begin
            if (!ipic_done) begin
               state_d = ARB_IDLE;
            end
         end
         ARB_HANG: begin
            start_d = 1'b0;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   assign req_ack    = ack_q;
   assign resp_valid = rv_q;
   assign resp_err   = err_q;
   assign resp_rdata = rdata_q;
   assign ipic_type  = type_q;
   assign ipic_start = start_q;
   assign read_addr  = addr_q;
   assign write_addr = addr_q;
   assign write_data = wdata_q;
   assign arb_hang   = hang_q;
   assign arb_state  = state_q;

endmodule
